// File: rtl/instruction_fetch.sv
// Instruction fetch stage. A program counter drives an instruction memory that
// answers in the same cycle. Fetched {pc, instr} pairs go into a 2-entry
// buffer that decode drains through a valid/ready handshake. A redirect from
// execute flushes the buffer and restarts fetch. Fetching an EBREAK parks the
// stage in HALT until the next redirect or reset.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted
);

  localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [31:0] pc_r;
  logic [1:0]  count_r;
  // Entry 0 is always the buffer head; entry 1 is the younger instruction.
  logic [31:0] pc0_r;
  logic [31:0] instr0_r;
  logic [31:0] pc1_r;
  logic [31:0] instr1_r;
  logic        pop_s;
  logic        push_s;
  logic        is_ebreak_s;
  logic [31:0] redirect_target_s;

  assign mem_addr          = pc_r;
  assign out_valid         = (count_r != 2'd0);
  assign out_instr         = instr0_r;
  assign out_pc            = pc0_r;
  assign pop_s             = out_valid & out_ready;
  // A full buffer can still accept a word when the head leaves this cycle.
  assign push_s            = (state_r == RUN) & ~redirect_valid &
                             ((count_r < 2'd2) | pop_s);
  assign is_ebreak_s       = (mem_rdata == EBREAK_WORD);
  // Redirect targets are forced to word alignment.
  assign redirect_target_s = redirect_pc & 32'hFFFF_FFFC;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state: EBREAK stops fetch, only a redirect restarts it.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      RUN: begin
        if (redirect_valid) begin
          state_next_s = RUN;
        end else if (push_s && is_ebreak_s) begin
          state_next_s = HALT;
        end else begin
          state_next_s = RUN;
        end
      end
      HALT: begin
        if (redirect_valid) begin
          state_next_s = RUN;
        end else begin
          state_next_s = HALT;
        end
      end
      default: begin
        state_next_s = RUN;
      end
    endcase
  end

  // FSM outputs: halted flag decoded from the state register.
  always_comb begin
    halted = 1'b0;
    case (state_r)
      RUN:     halted = 1'b0;
      HALT:    halted = 1'b1;
      default: halted = 1'b0;
    endcase
  end

  // Program counter: redirect wins, otherwise advance by one word per push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= RESET_PC;
    end else if (redirect_valid) begin
      pc_r <= redirect_target_s;
    end else if (push_s) begin
      pc_r <= pc_r + 32'd4;
    end else begin
      pc_r <= pc_r;
    end
  end

  // Two-entry shift buffer: pops shift entry 1 into the head, pushes fill
  // the lowest free slot, a redirect empties it without touching the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r  <= 2'd0;
      pc0_r    <= 32'd0;
      instr0_r <= 32'd0;
      pc1_r    <= 32'd0;
      instr1_r <= 32'd0;
    end else if (redirect_valid) begin
      count_r <= 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            pc0_r    <= pc_r;
            instr0_r <= mem_rdata;
          end else begin
            pc1_r    <= pc_r;
            instr1_r <= mem_rdata;
          end
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          pc0_r    <= pc1_r;
          instr0_r <= instr1_r;
          count_r  <= count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            pc0_r    <= pc_r;
            instr0_r <= mem_rdata;
          end else begin
            pc0_r    <= pc1_r;
            instr0_r <= instr1_r;
            pc1_r    <= pc_r;
            instr1_r <= mem_rdata;
          end
          count_r <= count_r;
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch. A reference model (a queue of
// {pc, instr} pairs, a fetch pointer and a halt flag) is advanced once per
// clock from the stage's rules and compared with the DUT on the falling edge.
module tb_instruction_fetch;

  localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

  logic        clk;
  logic        rst_n;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;

  logic [31:0] mem [0:255];
  assign mem_rdata = mem[mem_addr[9:2]];

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [63:0] mq[$];
  logic [31:0] m_pc;
  bit          m_halt;

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      if (mem[i] == EBREAK_WORD) mem[i] = 32'h0000_0013;
    end
  endtask

  // Hold reset over one clock, release on a falling edge, reset the model.
  task automatic do_reset();
    rst_n = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    @(negedge clk);
    mq.delete();
    m_pc = 32'h0000_0000;
    m_halt = 1'b0;
    rst_n = 1'b1;
  endtask

  // Drive inputs for one cycle, advance the model across the rising edge,
  // and return at the next falling edge.
  task automatic tick(input bit rdy, input bit rv, input logic [31:0] rpc);
    logic [31:0] w;
    bit          pop;
    out_ready = rdy;
    redirect_valid = rv;
    redirect_pc = rpc;
    pop = rdy && (mq.size() != 0);
    w = mem[m_pc[9:2]];
    @(posedge clk);
    if (rv) begin
      mq.delete();
      m_pc = {rpc[31:2], 2'b00};
      m_halt = 1'b0;
    end else begin
      if (pop) mq.delete(0);
      if (!m_halt && mq.size() < 2) begin
        mq.push_back({m_pc, w});
        if (w == EBREAK_WORD) m_halt = 1'b1;
        m_pc = m_pc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || halted !== 1'b0 || out_pc !== 32'd0 ||
        out_instr !== 32'd0 || mem_addr !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: valid=%b halted=%b pc=%h instr=%h addr=%h, want 0 0 0 0 0",
               out_valid, halted, out_pc, out_instr, mem_addr);
    end
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || mem_addr !== 32'd0) begin
      failures++;
      $display("FAIL reset_release: valid=%b addr=%h, want 0 00000000", out_valid, mem_addr);
    end
  endtask

  task automatic test_stream();
    logic [31:0] words [0:3];
    words[0] = 32'h0020_8093; words[1] = 32'h0070_8093;
    words[2] = 32'h0010_0023; words[3] = 32'h0010_8093;
    for (int i = 0; i < 4; i++) mem[i] = words[i];
    do_reset();
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, 1'b0, 32'd0);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || out_instr !== words[k]) begin
        failures++;
        $display("FAIL stream[%0d]: valid=%b pc=%h instr=%h, want 1 %h %h",
                 k, out_valid, out_pc, out_instr, 32'(4 * k), words[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      tick(1'b0, 1'b0, 32'd0);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'd0 || out_instr !== mem[0]) begin
        failures++;
        $display("FAIL hold[%0d]: valid=%b pc=%h instr=%h, want 1 00000000 %h",
                 k, out_valid, out_pc, out_instr, mem[0]);
      end
    end
    checks++;
    if (mem_addr !== 32'd8) begin
      failures++;
      $display("FAIL hold_pc: mem_addr=%h, want 00000008", mem_addr);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * k)) begin
        failures++;
        $display("FAIL release[%0d]: valid=%b pc=%h, want 1 %h", k, out_valid, out_pc, 32'(4 * k));
      end
      tick(1'b1, 1'b0, 32'd0);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 32'd0);
    tick(1'b1, 1'b1, 32'h0000_0023);
    checks++;
    if (out_valid !== 1'b0 || mem_addr !== 32'h20) begin
      failures++;
      $display("FAIL redirect_flush: valid=%b addr=%h, want 0 00000020", out_valid, mem_addr);
    end
    tick(1'b1, 1'b0, 32'd0);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h20 || out_instr !== mem[8]) begin
      failures++;
      $display("FAIL redirect_first: valid=%b pc=%h instr=%h, want 1 00000020 %h",
               out_valid, out_pc, out_instr, mem[8]);
    end
  endtask

  task automatic test_halt();
    bit saw28 = 1'b0;
    mem[7] = EBREAK_WORD;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      tick(1'b1, 1'b0, 32'd0);
      if (out_valid && out_pc == 32'd28) saw28 = 1'b1;
      checks++;
      if (out_valid === 1'b1 && out_pc > 32'd28) begin
        failures++;
        $display("FAIL halt_overrun: pc=%h delivered, want nothing past 0000001c", out_pc);
      end
    end
    checks++;
    if (!saw28 || halted !== 1'b1 || mem_addr !== 32'd32 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL halt_state: saw28=%b halted=%b addr=%h valid=%b, want 1 1 00000020 0",
               saw28, halted, mem_addr, out_valid);
    end
    tick(1'b1, 1'b1, 32'd0);
    checks++;
    if (halted !== 1'b0 || mem_addr !== 32'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL halt_redirect: halted=%b addr=%h valid=%b, want 0 00000000 0",
               halted, mem_addr, out_valid);
    end
    tick(1'b1, 1'b0, 32'd0);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'd0 || out_instr !== mem[0]) begin
      failures++;
      $display("FAIL halt_resume: valid=%b pc=%h instr=%h, want 1 00000000 %h",
               out_valid, out_pc, out_instr, mem[0]);
    end
  endtask

  task automatic test_async_reset();
    fill_mem();
    do_reset();
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 32'd0);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL pre_async: valid=%b, want 1", out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || halted !== 1'b0 || out_pc !== 32'd0 ||
        out_instr !== 32'd0 || mem_addr !== 32'd0) begin
      failures++;
      $display("FAIL async_reset: valid=%b halted=%b pc=%h instr=%h addr=%h, want 0 0 0 0 0",
               out_valid, halted, out_pc, out_instr, mem_addr);
    end
    @(negedge clk);
    mq.delete();
    m_pc = 32'd0;
    m_halt = 1'b0;
    rst_n = 1'b1;
    tick(1'b1, 1'b0, 32'd0);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'd0 || out_instr !== mem[0]) begin
      failures++;
      $display("FAIL async_restart: valid=%b pc=%h instr=%h, want 1 00000000 %h",
               out_valid, out_pc, out_instr, mem[0]);
    end
  endtask

  task automatic test_random();
    int errs = 0;
    fill_mem();
    for (int i = 0; i < 256; i++) if ($urandom_range(0, 39) == 0) mem[i] = EBREAK_WORD;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom);
      checks++;
      if (out_valid !== (mq.size() != 0) || mem_addr !== m_pc || halted !== m_halt ||
          (mq.size() != 0 && {out_pc, out_instr} !== mq[0])) begin
        failures++;
        errs++;
        if (errs <= 10)
          $display("FAIL random[%0d]: valid=%b addr=%h halted=%b pc=%h instr=%h, want %b %h %b %h",
                   k, out_valid, mem_addr, halted, out_pc, out_instr,
                   mq.size() != 0, m_pc, m_halt, (mq.size() != 0) ? mq[0] : 64'd0);
      end
    end
  endtask

  initial begin
    fill_mem();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
